// File: rtl/mem_pkg.sv
// Shared types and constants for the instruction/data RAM arbiter.
// The size decode folds the reserved encoding 3 onto a full word access.
package mem_pkg;

   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } size_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RMW_WR = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_D  = 1'b1
   } port_e;

   function automatic size_e decode_size(input logic [1:0] sz);
      case (sz)
         2'd0:    return SZ_B;
         2'd1:    return SZ_H;
         default: return SZ_W;
      endcase
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side fetch/data ports and RAM-macro port of the arbiter, bundled.
// slave = arbiter side, master = core plus RAM side.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 8
);
   import mem_pkg::*;

   logic              if_req;
   logic [WORD_W-1:0] if_addr;
   logic              if_ready;
   logic [WORD_W-1:0] if_rdata;

   logic              d_req;
   logic              d_we;
   logic [WORD_W-1:0] d_addr;
   logic [1:0]        d_size;
   logic              d_unsigned;
   logic [WORD_W-1:0] d_wdata;
   logic              d_ready;
   logic [WORD_W-1:0] d_rdata;
   logic              d_err;

   logic [ADDR_W-1:0] ram_addr;
   logic              ram_re;
   logic              ram_we;
   logic [WORD_W-1:0] ram_wdata;
   logic [WORD_W-1:0] ram_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_size, d_unsigned, d_wdata, ram_rdata,
      output if_ready, if_rdata, d_ready, d_rdata, d_err, ram_addr, ram_re, ram_we, ram_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_size, d_unsigned, d_wdata, ram_rdata,
      input  if_ready, if_rdata, d_ready, d_rdata, d_err, ram_addr, ram_re, ram_we, ram_wdata
   );

endinterface

// File: rtl/mem_lane_fmt.sv
// Byte/half lane handling: load extract + extend, and sub-word store merge
// into the word read back from RAM. Purely combinational, little-endian lanes.
module mem_lane_fmt
   import mem_pkg::*;
(
   input  logic [WORD_W-1:0] rdata,
   input  logic [1:0]        byte_sel,
   input  size_e             size,
   input  logic              is_unsigned,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] load_data_c,
   output logic [WORD_W-1:0] merge_data_c
);

   logic [4:0]  byte_sh;
   logic [4:0]  half_sh;
   logic [7:0]  load_b;
   logic [15:0] load_h;

   always_comb begin
      byte_sh      = {byte_sel, 3'b000};
      half_sh      = {byte_sel[1], 4'b0000};
      load_b       = 8'(rdata >> byte_sh);
      load_h       = 16'(rdata >> half_sh);
      load_data_c  = rdata;
      merge_data_c = wdata;
      case (size)
         SZ_B: begin
            load_data_c  = is_unsigned ? WORD_W'(load_b) : {{(WORD_W-8){load_b[7]}}, load_b};
            merge_data_c = (rdata & ~(WORD_W'(8'hFF) << byte_sh)) |
                           (WORD_W'(wdata[7:0]) << byte_sh);
         end
         SZ_H: begin
            load_data_c  = is_unsigned ? WORD_W'(load_h) : {{(WORD_W-16){load_h[15]}}, load_h};
            merge_data_c = (rdata & ~(WORD_W'(16'hFFFF) << half_sh)) |
                           (WORD_W'(wdata[15:0]) << half_sh);
         end
         default: begin
            load_data_c  = rdata;
            merge_data_c = wdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port 32-bit RAM between instruction fetch and load/store,
// with round-robin (or data-first) arbitration and read-modify-write for SB/SH.
// Optional MEM_MISALIGN_TRAP_EN: misaligned data accesses skip the RAM and return d_err.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter bit          RR     = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_arbiter_if.slave bus
);

   arb_state_e        state_q, state_d;
   port_e             grant_q, grant_d;
   port_e             last_grant_q, last_grant_d;
   logic              err_q, err_d;

   port_e             pick_c;
   size_e             size_c;
   logic              misalign_c;
   logic              sub_store_c;
   logic [ADDR_W-1:0] if_waddr_c;
   logic [ADDR_W-1:0] d_waddr_c;
   logic [WORD_W-1:0] load_data_c;
   logic [WORD_W-1:0] merge_data_c;

   mem_lane_fmt u_lane_fmt (
      .rdata        (bus.ram_rdata),
      .byte_sel     (bus.d_addr[1:0]),
      .size         (size_c),
      .is_unsigned  (bus.d_unsigned),
      .wdata        (bus.d_wdata),
      .load_data_c  (load_data_c),
      .merge_data_c (merge_data_c)
   );

   // Request decode; word addresses wrap modulo the RAM depth.
   always_comb begin
      size_c      = decode_size(bus.d_size);
      sub_store_c = bus.d_we && (size_c != SZ_W);
      if_waddr_c  = ADDR_W'(bus.if_addr >> 2);
      d_waddr_c   = ADDR_W'(bus.d_addr >> 2);
      if (bus.if_req && bus.d_req) begin
         pick_c = (RR && (last_grant_q == PORT_D)) ? PORT_IF : PORT_D;
      end else if (bus.d_req) begin
         pick_c = PORT_D;
      end else begin
         pick_c = PORT_IF;
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign_c = ((size_c == SZ_H) && bus.d_addr[0]) ||
                       ((size_c == SZ_W) && (bus.d_addr[1:0] != 2'b00));
`else
   assign misalign_c = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= PORT_IF;
         last_grant_q <= PORT_D;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         err_q        <= err_d;
      end
   end

   // Grants are only taken in IDLE; RESP always returns to IDLE.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      err_d        = err_q;
      unique case (state_q)
         IDLE: begin
            if (bus.if_req || bus.d_req) begin
               grant_d      = pick_c;
               last_grant_d = pick_c;
               err_d        = (pick_c == PORT_D) && misalign_c;
               if ((pick_c == PORT_D) && !misalign_c && sub_store_c) begin
                  state_d = RMW_WR;
               end else begin
                  state_d = RESP;
               end
            end
         end
         RMW_WR:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are held at zero while reset is asserted so an abandoned RMW never writes.
   always_comb begin
      bus.if_ready  = 1'b0;
      bus.if_rdata  = '0;
      bus.d_ready   = 1'b0;
      bus.d_rdata   = '0;
      bus.d_err     = 1'b0;
      bus.ram_addr  = '0;
      bus.ram_re    = 1'b0;
      bus.ram_we    = 1'b0;
      bus.ram_wdata = '0;
      if (rst_n) begin
         unique case (state_q)
            IDLE: begin
               if (bus.if_req || bus.d_req) begin
                  if (pick_c == PORT_IF) begin
                     bus.ram_addr = if_waddr_c;
                     bus.ram_re   = 1'b1;
                  end else if (!misalign_c) begin
                     bus.ram_addr = d_waddr_c;
                     if (bus.d_we && (size_c == SZ_W)) begin
                        bus.ram_we    = 1'b1;
                        bus.ram_wdata = bus.d_wdata;
                     end else begin
                        bus.ram_re = 1'b1;
                     end
                  end
               end
            end
            RMW_WR: begin
               bus.ram_addr  = d_waddr_c;
               bus.ram_we    = 1'b1;
               bus.ram_wdata = merge_data_c;
            end
            RESP: begin
               if (grant_q == PORT_IF) begin
                  bus.if_ready = 1'b1;
                  bus.if_rdata = bus.ram_rdata;
               end else begin
                  bus.d_ready = 1'b1;
                  bus.d_err   = err_q;
                  bus.d_rdata = (bus.d_we || err_q) ? '0 : load_data_c;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cases with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the RAM.
module tb_mem_arbiter;
   import mem_pkg::*;

   localparam int unsigned AW    = 8;
   localparam int unsigned DEPTH = 1 << AW;
`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW)) bus ();
   mem_arbiter #(.ADDR_W(AW), .RR(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   // RAM macro: registered read, full-word write, plus a preload port.
   logic [31:0]   ram [DEPTH];
   logic [31:0]   ram_rdata_q;
   logic          pl_en;
   logic [AW-1:0] pl_addr;
   logic [31:0]   pl_data;
   always @(posedge clk) begin
      if (pl_en) ram[pl_addr] <= pl_data;
      else if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
      if (bus.ram_re) ram_rdata_q <= ram[bus.ram_addr];
   end
   assign bus.ram_rdata = ram_rdata_q;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [AW-1:0] wa(input logic [31:0] a);
      return AW'(a >> 2);
   endfunction

   function automatic bit misaligned(input logic [1:0] a, input logic [1:0] sz);
      if (!TRAP_EN) return 1'b0;
      if (sz == 2'd0) return 1'b0;
      if (sz == 2'd1) return a[0];
      return a != 2'b00;
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] a,
                                            input logic [1:0] sz, input logic uns);
      logic [7:0]  b [4];
      logic [15:0] h;
      for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
      h = a[1] ? {b[3], b[2]} : {b[1], b[0]};
      case (sz)
         2'd0:    return uns ? {24'h0, b[a]} : {{24{b[a][7]}}, b[a]};
         2'd1:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] exp_store(input logic [31:0] w, input logic [1:0] a,
                                             input logic [1:0] sz, input logic [31:0] wd);
      logic [7:0] b [4];
      for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
      case (sz)
         2'd0: b[a] = wd[7:0];
         2'd1: begin
            b[{a[1], 1'b0}] = wd[7:0];
            b[{a[1], 1'b1}] = wd[15:8];
         end
         default: return wd;
      endcase
      return {b[3], b[2], b[1], b[0]};
   endfunction

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2) |
          32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | 32'hFFFF_F000;
      return a;
   endfunction

   // Transaction-level model: each grant schedules a ready (and maybe a write) some cycles ahead.
   logic [31:0]   model_mem [DEPTH];
   int            rdy_cyc = -1;
   int            wr_cyc = -1;
   int            free_cyc = 0;
   port_e         last_m = PORT_D;
   port_e         gport = PORT_IF;
   port_e         p;
   logic [31:0]   exp_data;
   logic          exp_err;
   logic [31:0]   new_word;
   logic [AW-1:0] wr_addr;
   int            if_wait = 0;
   int            d_wait = 0;

   always @(negedge clk) begin
      cyc++;
      if (pl_en) model_mem[pl_addr] = pl_data;
      if (!rst_n) begin
         check("rst_strobes", 32'({bus.if_ready, bus.d_ready, bus.ram_re, bus.ram_we, bus.d_err}), 32'h0);
         check("rst_buses", 32'(|{bus.if_rdata, bus.d_rdata, bus.ram_wdata, bus.ram_addr}), 32'h0);
         rdy_cyc = -1; wr_cyc = -1; free_cyc = cyc + 1; last_m = PORT_D;
         if_wait = 0; d_wait = 0;
      end else begin
         if (cyc >= free_cyc && (bus.if_req || bus.d_req)) begin
            if (bus.if_req && bus.d_req) p = (last_m == PORT_D) ? PORT_IF : PORT_D;
            else p = bus.d_req ? PORT_D : PORT_IF;
            last_m = p; gport = p;
            exp_data = 32'h0; exp_err = 1'b0; wr_cyc = -1; rdy_cyc = cyc + 1;
            if (p == PORT_IF) begin
               exp_data = model_mem[wa(bus.if_addr)];
            end else if (misaligned(bus.d_addr[1:0], bus.d_size)) begin
               exp_err = 1'b1;
            end else if (bus.d_we) begin
               wr_addr  = wa(bus.d_addr);
               new_word = exp_store(model_mem[wr_addr], bus.d_addr[1:0], bus.d_size, bus.d_wdata);
               if (bus.d_size < 2'd2) rdy_cyc = cyc + 2;
               wr_cyc = rdy_cyc - 1;
            end else begin
               exp_data = exp_load(model_mem[wa(bus.d_addr)], bus.d_addr[1:0], bus.d_size, bus.d_unsigned);
            end
            free_cyc = rdy_cyc + 1;
         end
         check("ram_we", 32'(bus.ram_we), 32'(cyc == wr_cyc));
         if (cyc == wr_cyc) begin
            check("ram_waddr", 32'(bus.ram_addr), 32'(wr_addr));
            check("ram_wdata", bus.ram_wdata, new_word);
            model_mem[wr_addr] = new_word;
         end
         check("if_ready", 32'(bus.if_ready), 32'(cyc == rdy_cyc && gport == PORT_IF));
         check("d_ready", 32'(bus.d_ready), 32'(cyc == rdy_cyc && gport == PORT_D));
         if (cyc == rdy_cyc && gport == PORT_IF) check("if_rdata", bus.if_rdata, exp_data);
         if (cyc == rdy_cyc && gport == PORT_D) begin
            check("d_rdata", bus.d_rdata, exp_data);
            check("d_err", 32'(bus.d_err), 32'(exp_err));
         end
         if_wait = (bus.if_req && !bus.if_ready) ? if_wait + 1 : 0;
         d_wait  = (bus.d_req && !bus.d_ready) ? d_wait + 1 : 0;
         check("if_wait_bound", 32'(if_wait > 12), 32'h0);
         check("d_wait_bound", 32'(d_wait > 12), 32'h0);
      end
   end

   task automatic preload(input int unsigned w, input logic [31:0] v);
      pl_en = 1'b1; pl_addr = AW'(w); pl_data = v;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic run_if(input logic [31:0] addr, output logic [31:0] rd, output int lat);
      bus.if_req = 1'b1; bus.if_addr = addr; lat = -1; rd = '0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.if_ready) begin lat = k; rd = bus.if_rdata; break; end
      end
      @(posedge clk); #1;
      bus.if_req = 1'b0;
   endtask

   task automatic run_d(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int n_re, output int n_we, output logic [31:0] wseen);
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_size = sz;
      bus.d_unsigned = uns; bus.d_wdata = wd;
      lat = -1; n_re = 0; n_we = 0; wseen = '0; rd = '0; er = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.ram_re) n_re++;
         if (bus.ram_we) begin n_we++; wseen = bus.ram_wdata; end
         if (bus.d_ready) begin lat = k; rd = bus.d_rdata; er = bus.d_err; break; end
      end
      @(posedge clk); #1;
      bus.d_req = 1'b0;
   endtask

   logic [31:0] rd, wseen;
   logic        er;
   int          lat, n_re, n_we, nrdy;
   int          order [$];
   logic        if_seen, d_seen;

   initial begin
      rst_n = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_size = '0;
      bus.d_unsigned = 1'b0; bus.d_wdata = '0;
      @(posedge clk); #1;
      for (int i = 0; i < int'(DEPTH); i++) preload(i, $urandom);
      preload(4, 32'h00A00093);
      preload(8, 32'h80FF7F01);
      rst_n = 1'b1;

      // Fetch only
      run_if(32'h10, rd, lat);
      check("fetch_data", rd, 32'h00A00093);
      check("fetch_lat", 32'(lat), 32'd1);

      // Contention straight out of reset: fetch first, then alternating
      rst_n = 1'b0;
      bus.if_req = 1'b1; bus.if_addr = 32'h10;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20; bus.d_size = 2'd2; bus.d_unsigned = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.if_ready) order.push_back(0);
         if (bus.d_ready) order.push_back(1);
      end
      @(posedge clk); #1;
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      check("rr_count", 32'(order.size()), 32'd6);
      if (order.size() >= 4) begin
         for (int i = 0; i < 4; i++) check("rr_order", 32'(order[i]), 32'(i % 2));
      end

      // Sub-word loads
      run_d(1'b0, 32'h23, 2'd0, 1'b0, 32'h0, rd, er, lat, n_re, n_we, wseen);
      check("lb_0x23", rd, 32'hFFFFFF80);
      check("lb_lat", 32'(lat), 32'd1);
      run_d(1'b0, 32'h23, 2'd0, 1'b1, 32'h0, rd, er, lat, n_re, n_we, wseen);
      check("lbu_0x23", rd, 32'h00000080);
      run_d(1'b0, 32'h22, 2'd1, 1'b0, 32'h0, rd, er, lat, n_re, n_we, wseen);
      check("lh_0x22", rd, 32'hFFFF80FF);

      // Misaligned word load
      run_d(1'b0, 32'h22, 2'd2, 1'b0, 32'h0, rd, er, lat, n_re, n_we, wseen);
      check("lw_0x22_data", rd, TRAP_EN ? 32'h0 : 32'h80FF7F01);
      check("lw_0x22_err", 32'(er), 32'(TRAP_EN));
      check("lw_0x22_ram_ops", 32'(n_re + n_we), TRAP_EN ? 32'd0 : 32'd1);

      // Byte store via read-modify-write
      preload(8, 32'h11223344);
      run_d(1'b1, 32'h21, 2'd0, 1'b0, 32'h000000AB, rd, er, lat, n_re, n_we, wseen);
      check("sb_merge", wseen, 32'h1122AB44);
      check("sb_lat", 32'(lat), 32'd2);
      check("sb_we_count", 32'(n_we), 32'd1);
      check("sb_rdata", rd, 32'h0);

      // Reset during the write phase of an RMW
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20; bus.d_size = 2'd0; bus.d_wdata = 32'h55;
      @(posedge clk); #1;
      rst_n = 1'b0; bus.d_req = 1'b0;
      @(negedge clk);
      check("rst_rmw_we", 32'(bus.ram_we), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      nrdy = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.d_ready) nrdy++;
      end
      check("rst_no_ready", 32'(nrdy), 32'h0);
      check("rst_ram_kept", ram[8], 32'h1122AB44);
      @(posedge clk); #1;

      // Random traffic
      if_seen = 1'b0; d_seen = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (bus.if_ready) if_seen = 1'b1;
         if (bus.d_ready) d_seen = 1'b1;
         @(posedge clk); #1;
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
         if (!bus.if_req || if_seen) begin
            if_seen = 1'b0;
            bus.if_req = ($urandom_range(0, 2) != 0);
            bus.if_addr = rnd_addr();
         end
         if (!bus.d_req || d_seen) begin
            d_seen = 1'b0;
            bus.d_req = ($urandom_range(0, 2) != 0);
            bus.d_we = 1'($urandom_range(0, 1));
            bus.d_addr = rnd_addr();
            bus.d_size = 2'($urandom_range(0, 3));
            bus.d_unsigned = 1'($urandom_range(0, 1));
            bus.d_wdata = $urandom;
         end
      end
      bus.if_req = 1'b0; bus.d_req = 1'b0; rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      for (int i = 0; i < int'(DEPTH); i++) check("ram_final", ram[i], model_mem[i]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
